ps2_scancode_decoder: RTL and testbench

//   Consumes raw scan-code bytes from the PS/2 receive stage (set 2) and folds the E0/F0/E1

---
 rtl/ps2_scancode_decoder.sv | 196 +++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_scancode_decoder
//  Description : Folds PS/2 set-2 scan-code byte sequences (E0 / F0 / E1
//                prefixes) into single key events and queues them in an
//                event FIFO presented through a valid/ready interface.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                byte_valid/byte_data  - received byte strobe and value
//                event_valid/ready     - head-of-FIFO handshake
//                event_code/extended/release/pause - head event fields
//                overflow/clear_overflow - sticky drop flag and its clear
//                seq_error             - pulse on timeout or 00/FF byte
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       event_valid,
    input  logic       event_ready,
    output logic [7:0] event_code,
    output logic       event_extended,
    output logic       event_release,
    output logic       event_pause,
    output logic       overflow,
    input  logic       clear_overflow,
    output logic       seq_error
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [TW-1:0] C_TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] C_FULL      = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_E0    = 3'd1,
        ST_F0    = 3'd2,
        ST_E0F0  = 3'd3,
        ST_PAUSE = 3'd4
    } state_t;

    // Decoder state
    state_t          r_state;
    logic [2:0]      r_cnt;
    logic [TW-1:0]   r_timer;
    logic            r_seq_error;

    // Event FIFO; entry layout is {pause, extended, release, code}
    logic [10:0]     r_mem [0:FIFO_DEPTH-1];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;

    // Next-state decode
    state_t          w_next_state;
    logic [2:0]      w_next_cnt;
    logic            w_push;
    logic [10:0]     w_entry;
    logic            w_err;
    logic            w_err_byte;
    logic            w_fake_shift;
    logic            w_full;
    logic            w_pop;
    logic            w_write;

    assign w_err_byte   = (byte_data == 8'h00) || (byte_data == 8'hFF);
    // E0-prefixed 12/59 are the keyboard's synthetic shift codes around
    // navigation keys; they carry no key information and are dropped.
    assign w_fake_shift = (byte_data == 8'h12) || (byte_data == 8'h59);

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_push       = 1'b0;
        w_entry      = {3'b000, byte_data};
        w_err        = 1'b0;
        if (byte_valid) begin
            if (w_err_byte) begin
                w_err        = 1'b1;
                w_next_state = ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        case (byte_data)
                            8'hE0: w_next_state = ST_E0;
                            8'hF0: w_next_state = ST_F0;
                            8'hE1: begin
                                w_next_state = ST_PAUSE;
                                w_next_cnt   = 3'd7;
                            end
                            8'hFA, 8'hAA, 8'hEE, 8'hFE: w_push = 1'b0;
                            default: w_push = 1'b1;
                        endcase
                    end
                    ST_E0: begin
                        if (byte_data == 8'hF0) begin
                            w_next_state = ST_E0F0;
                        end else begin
                            w_push       = !w_fake_shift;
                            w_entry      = {3'b010, byte_data};
                            w_next_state = ST_IDLE;
                        end
                    end
                    ST_F0: begin
                        w_push       = 1'b1;
                        w_entry      = {3'b001, byte_data};
                        w_next_state = ST_IDLE;
                    end
                    ST_E0F0: begin
                        w_push       = !w_fake_shift;
                        w_entry      = {3'b011, byte_data};
                        w_next_state = ST_IDLE;
                    end
                    ST_PAUSE: begin
                        // The 7 bytes after E1 are counted, not inspected.
                        w_next_cnt = r_cnt - 3'd1;
                        if (r_cnt == 3'd1) begin
                            w_push       = 1'b1;
                            w_entry      = {3'b100, 8'h77};
                            w_next_state = ST_IDLE;
                        end
                    end
                    default: w_next_state = ST_IDLE;
                endcase
            end
        end else if ((r_state != ST_IDLE) && (r_timer == C_TIMER_MAX)) begin
            w_err        = 1'b1;
            w_next_state = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            r_timer     <= '0;
            r_seq_error <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_seq_error <= w_err;
            if (byte_valid || (w_next_state == ST_IDLE))
                r_timer <= '0;
            else
                r_timer <= r_timer + TW'(1);
        end
    end

    // A pop frees a slot on the same edge, so a full FIFO still accepts a
    // push when the consumer is draining.
    assign w_full  = (r_count == C_FULL);
    assign w_pop   = event_valid && event_ready;
    assign w_write = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_mem[i] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_write) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (clear_overflow)
                r_overflow <= 1'b0;
            else if (w_push && w_full && !w_pop)
                r_overflow <= 1'b1;
        end
    end

    assign event_valid = (r_count != '0);
    assign {event_pause, event_extended, event_release, event_code} = r_mem[r_rd_ptr];
    assign overflow    = r_overflow;
    assign seq_error   = r_seq_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_scancode_decoder
//  Description : Scoreboard bench for ps2_scancode_decoder. Directed byte
//                sequences push expected events into a queue; a monitor
//                pops and compares on every accepted event.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_scancode_decoder;

    localparam int FIFO_DEPTH     = 8;
    localparam int TIMEOUT_CYCLES = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       event_valid;
    logic       event_ready = 1'b0;
    logic [7:0] event_code;
    logic       event_extended;
    logic       event_release;
    logic       event_pause;
    logic       overflow;
    logic       clear_overflow = 1'b0;
    logic       seq_error;

    int errors = 0;
    int checks = 0;
    int err_pulses = 0;
    logic [10:0] exp_q[$];

    ps2_scancode_decoder #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .byte_valid     (byte_valid),
        .byte_data      (byte_data),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .event_code     (event_code),
        .event_extended (event_extended),
        .event_release  (event_release),
        .event_pause    (event_pause),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .seq_error      (seq_error)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] ev(input logic [7:0] code, input logic ext,
                                       input logic rel, input logic pause);
        return {pause, ext, rel, code};
    endfunction

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || event_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, {31'd0, event_valid}, 32'd0);
        check({name, "_queue"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!reset) begin
                    if (seq_error)
                        err_pulses++;
                    if (event_valid && event_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_event: actual=%0h required=none",
                                     {event_pause, event_extended, event_release, event_code});
                        end else begin
                            logic [10:0] e;
                            e = exp_q.pop_front();
                            if ({event_pause, event_extended, event_release, event_code} !== e) begin
                                errors++;
                                $display("FAIL event: actual=%0h required=%0h",
                                         {event_pause, event_extended, event_release, event_code}, e);
                            end
                        end
                    end
                end
            end
        join_none

        begin
            int base;
            idle(3);
            check("reset_valid", {31'd0, event_valid}, 32'd0);
            check("reset_code", {24'd0, event_code}, 32'd0);
            check("reset_flags", {29'd0, event_extended, event_release, event_pause}, 32'd0);
            check("reset_overflow", {31'd0, overflow}, 32'd0);
            check("reset_seq_error", {31'd0, seq_error}, 32'd0);
            reset = 1'b0;
            idle(2);

            // Make and break held until ready
            exp_q.push_back(ev(8'h1C, 0, 0, 0));
            exp_q.push_back(ev(8'h1C, 0, 1, 0));
            send(8'h1C); send(8'hF0); send(8'h1C);
            idle(4);
            check("held_valid", {31'd0, event_valid}, 32'd1);
            check("held_code", {24'd0, event_code}, 32'h1C);
            event_ready = 1'b1;
            drain("basic");

            // Extended make/break, print screen, fake-shift break, ack/BAT ignored
            exp_q.push_back(ev(8'h75, 1, 0, 0));
            exp_q.push_back(ev(8'h75, 1, 1, 0));
            exp_q.push_back(ev(8'h7C, 1, 0, 0));
            send(8'hE0); send(8'h75);
            send(8'hE0); send(8'hF0); send(8'h75);
            send(8'hE0); send(8'h12); send(8'hE0); send(8'h7C);
            send(8'hE0); send(8'hF0); send(8'h12);
            send(8'hFA); send(8'hAA); send(8'hEE); send(8'hFE);
            drain("extended");

            // Pause sequence yields exactly one event
            exp_q.push_back(ev(8'h77, 0, 0, 1));
            send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
            send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
            drain("pause");

            // Error bytes: FF in IDLE, 00 aborting an F0 sequence
            base = err_pulses;
            send(8'hFF);
            send(8'hF0); send(8'h00);
            idle(2);
            check("err_bytes", err_pulses - base, 32'd2);
            exp_q.push_back(ev(8'h2A, 0, 0, 0));
            send(8'h2A);
            drain("after_err");

            // Timeout after E0
            base = err_pulses;
            send(8'hE0);
            idle(TIMEOUT_CYCLES + 2);
            check("timeout_pulse", err_pulses - base, 32'd1);
            exp_q.push_back(ev(8'h1C, 0, 0, 0));
            send(8'h1C);
            drain("timeout");

            // Overflow: FIFO_DEPTH+1 makes with consumer stalled
            event_ready = 1'b0;
            for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
                if (i < FIFO_DEPTH)
                    exp_q.push_back(ev(8'h10 + 8'(i), 0, 0, 0));
                send(8'h10 + 8'(i));
            end
            idle(1);
            check("overflow_set", {31'd0, overflow}, 32'd1);
            event_ready = 1'b1;
            drain("overflow");
            clear_overflow = 1'b1;
            idle(1);
            clear_overflow = 1'b0;
            check("overflow_clear", {31'd0, overflow}, 32'd0);

            // Full FIFO, push coinciding with pop
            event_ready = 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                exp_q.push_back(ev(8'h30 + 8'(i), 0, 0, 0));
                send(8'h30 + 8'(i));
            end
            exp_q.push_back(ev(8'h44, 0, 0, 0));
            event_ready = 1'b1;
            send(8'h44);
            check("full_pushpop_overflow", {31'd0, overflow}, 32'd0);
            drain("full_pushpop");

            // Reset in the middle of E0 F0 with events queued
            event_ready = 1'b0;
            send(8'h21); send(8'h22);
            send(8'hE0); send(8'hF0);
            reset = 1'b1;
            idle(1);
            reset = 1'b0;
            exp_q.delete();
            check("reset_mid_valid", {31'd0, event_valid}, 32'd0);
            exp_q.push_back(ev(8'h1C, 0, 0, 0));
            send(8'h1C);
            event_ready = 1'b1;
            drain("reset_mid");

            idle(2);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

endmodule
`default_nettype wire
